// File: rtl/result_checker_if.sv
// Stimulus/result bus seen by result_checker.
// Carries the operands driven into the DUT and the DUT's result.
interface result_checker_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               op_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] result;

  modport master (
    output in_valid, op_mode, a, b, result
  );

  modport slave (
    input in_valid, op_mode, a, b, result
  );
endinterface

// File: rtl/result_checker.sv
// Hardware scoreboard: aligns operands with the DUT result,
// compares, counts outcomes and captures the first failure.
module result_checker #(
  parameter int WIDTH     = 8,
  parameter int LATENCY   = 2,
  parameter int CNT_W     = 16,
  parameter bit ADD_CARRY = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  result_checker_if.slave    bus,
  output logic               chk_valid,
  output logic               chk_pass,
  output logic [CNT_W-1:0]   test_count,
  output logic [CNT_W-1:0]   pass_count,
  output logic [CNT_W-1:0]   fail_count,
  output logic               err_sticky,
  output logic [WIDTH-1:0]   ff_a,
  output logic [WIDTH-1:0]   ff_b,
  output logic [2*WIDTH-1:0] ff_exp,
  output logic [2*WIDTH-1:0] ff_got,
  output logic [CNT_W-1:0]   ff_idx
);

  typedef struct packed {
    logic             vld;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } ent_t;

  ent_t               pipe [LATENCY];
  ent_t               tail;
  logic [WIDTH:0]     sum_c;
  logic [2*WIDTH-1:0] expected;
  logic               match;
  logic               flush;

  assign flush = reset | clear;
  assign tail  = pipe[LATENCY-1];

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Alignment shift register; never stalls, flushed by reset/clear.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < LATENCY; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= ent_t'{bus.in_valid, bus.op_mode, bus.a, bus.b};
      for (int i = 1; i < LATENCY; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign sum_c = {1'b0, tail.a} + {1'b0, tail.b};

  // Expected value for the entry leaving the pipeline.
  always_comb begin
    expected = '0;
    if (tail.op)
      expected = {{WIDTH{1'b0}}, tail.a} * {{WIDTH{1'b0}}, tail.b};
    else if (ADD_CARRY)
      expected[WIDTH:0] = sum_c;
    else
      expected[WIDTH-1:0] = sum_c[WIDTH-1:0];
  end

  assign match = (bus.result == expected);

  // Compare, count and first-failure capture.
  always_ff @(posedge clk) begin
    if (flush) begin
      chk_valid  <= 1'b0;
      chk_pass   <= 1'b0;
      test_count <= '0;
      pass_count <= '0;
      fail_count <= '0;
      err_sticky <= 1'b0;
      ff_a       <= '0;
      ff_b       <= '0;
      ff_exp     <= '0;
      ff_got     <= '0;
      ff_idx     <= '0;
    end else begin
      chk_valid <= tail.vld;
      chk_pass  <= tail.vld & match;
      if (tail.vld) begin
        test_count <= sat_inc(test_count);
        if (match) begin
          pass_count <= sat_inc(pass_count);
        end else begin
          fail_count <= sat_inc(fail_count);
          if (!err_sticky) begin
            err_sticky <= 1'b1;
            ff_a       <= tail.a;
            ff_b       <= tail.b;
            ff_exp     <= expected;
            ff_got     <= bus.result;
            ff_idx     <= test_count;
          end
        end
      end
    end
  end

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Hardware scoreboard placed directly downstream of dut_wrapper. It consumes the wrapper's result port and checks it against the operands that produced it.
- Operands and operation are captured when they are applied. They travel through a LATENCY-deep alignment pipeline. When they reach the end, the matching result sample is compared with a locally computed expected value.
- Keeps saturating test/pass/fail counters and captures the first failing vector. This allows self-checking without a simulator-only testbench.

Parameters:
- WIDTH, 8, operand width; result and expected values are 2*WIDTH bits.
- LATENCY, 2, cycles from in_valid to result being valid; legal range 1..16.
- CNT_W, 16, width of the test/pass/fail counters.
- ADD_CARRY, 1, when 1 the add expectation keeps the carry (WIDTH+1-bit sum); when 0 the sum is truncated to WIDTH bits.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous clear of counters, capture registers and pipeline.
- in_valid  input  1  operands a/b and op_mode are applied this cycle.
- op_mode  input  1  0 = add, 1 = multiply.
- a  input  WIDTH  operand A, as driven into the DUT.
- b  input  WIDTH  operand B, as driven into the DUT.
- result  input  2*WIDTH  DUT result.
- chk_valid  output  1  one-cycle pulse: a comparison happened this cycle.
- chk_pass  output  1  comparison outcome; meaningful only while chk_valid=1.
- test_count  output  CNT_W  comparisons performed.
- pass_count  output  CNT_W  passing comparisons.
- fail_count  output  CNT_W  failing comparisons.
- err_sticky  output  1  set on the first failure, held until reset or clear.
- ff_a  output  WIDTH  operand A of the first failure.
- ff_b  output  WIDTH  operand B of the first failure.
- ff_exp  output  2*WIDTH  expected value of the first failure.
- ff_got  output  2*WIDTH  result value of the first failure.
- ff_idx  output  CNT_W  test_count value (pre-increment) at the first failure.

Behaviour:
- Reset: all outputs are 0 and every pipeline valid bit is cleared.
- Reset asserted mid-operation discards all in-flight entries; no comparison occurs for them.
- Alignment pipeline: a shift register of LATENCY stages holding {valid, op_mode, a, b}.
  - Stage 0 loads on every cycle with valid = in_valid.
  - Entries advance one stage per cycle and never stall.
  - Back-to-back in_valid is allowed: one entry per cycle, and LATENCY entries can be in flight at once.
- Compare timing: an entry captured at edge N is compared against result sampled at edge N+LATENCY.
  - The registered outputs (chk_valid, chk_pass, counters) update at that same edge.
  - They are therefore visible in the cycle after edge N+LATENCY.
- Expected value for add:
  - ADD_CARRY=1: zero-extend a+b computed at WIDTH+1 bits.
  - ADD_CARRY=0: zero-extend (a+b) mod 2^WIDTH.
- Expected value for multiply: full 2*WIDTH-bit unsigned product.
- On a comparison:
  - test_count increments.
  - pass_count increments when result == expected; otherwise fail_count increments.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- First-failure capture: on a failure while err_sticky=0, load the ff_* registers and set err_sticky. Later failures leave ff_* unchanged.
- clear: same effect as reset on all outputs and the pipeline.
  - When clear coincides with a comparison, clear wins: no count is taken and chk_valid=0.
  - When clear coincides with in_valid, the new entry is also discarded.
- chk_valid is 0 in every cycle without a comparison. chk_pass is 0 whenever chk_valid=0.
- reset has priority over clear.

Test Plan:
- LATENCY=2, ADD_CARRY=1, add: (5,3), (255,1), (127,129), each issued with a single-cycle in_valid, and result driven with 8, 256, 256 two edges later. Required: three chk_valid pulses, pass_count=3, fail_count=0, err_sticky=0.
- Multiply, back-to-back on consecutive cycles: (15,2), (128,128), (255,255), with result following at 2-cycle offset as 30, 16384, 65025. Required: test_count=3, pass_count=3, pulses on three consecutive cycles.
- Injected faults: add (10,4) with result=13, then add (1,1) with result=5. Required: fail_count=2, err_sticky=1, ff_a=10, ff_b=4, ff_exp=14, ff_got=13, ff_idx=0.
- ADD_CARRY=0, add (255,1), result=0. Required: pass. The same vector with ADD_CARRY=1 and result=0 is required to fail with ff_exp=256.
- Two entries in flight, then reset asserted for one cycle. Required: no chk_valid pulse, all counters 0.
- Repeat with clear in place of reset. Required: same outcome as with reset. Additionally, clear asserted in the same cycle as a comparison is required to leave test_count=0.
- CNT_W=4, 20 passing vectors. Required: test_count=pass_count=15 (saturated).
